lz_lookahead_buffer: RTL and testbench
======================================

LZ_LOOKAHEAD_BUFFER -- requirements
Module: lz_lookahead_buffer

Interface
REQ-001 Parameter MIN_MATCH, default 3: the shortest match length the block encodes as a match token.
REQ-002 Parameter IDX_W, default 12: width of the history index.
REQ-003 clock  input  1  single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 inData_valid / inData_ready  input / output  1 / 1  handshake for the uncompressed byte stream.
REQ-006 inData_bits  input  8  uncompressed byte.
REQ-007 inData_last  input  1  qualifies inData_bits as the final byte of the stream.
REQ-008 patternData_valid / patternData_ready  output / input  1 / 1  pattern request to the search stage.
REQ-009 patternData_pattern  output  56  lookahead bytes; byte k is on bits [8k+7:8k], and byte 0 is the oldest.
REQ-010 patternData_length  output  3  number of valid lookahead bytes, 1..7.
REQ-011 matchResult_valid / matchResult_ready  input / output  1 / 1  result returned by the search stage.
REQ-012 matchResult_index / matchResult_length  input  IDX_W / 3  match position and match length, 0..7.
REQ-013 writeData_valid / writeData_ready / writeData_bits  output / input / output  1 / 1 / 8  retired bytes written into the search history.
REQ-014 token_valid / token_ready  output / input  1 / 1  handshake for the output token.
REQ-015 token_isMatch / token_literal / token_index / token_length  output  1 / 8 / IDX_W / 3  token fields.
REQ-016 done  output  1  high when the stream is fully retired.

Function
REQ-017 State: 7-byte buffer buf[0..6]; count (0..7); eos flag; remaining-retire counter rem (0..7); FSM with states FILL, SEARCH, WAIT, EMIT, RETIRE, DONE.
REQ-018 FILL behaviour:
- inData_ready = (count<7 && !eos).
- An accepted byte is written to buf[count] and count increments.
- inData_last on an accepted beat sets eos.
REQ-019 FILL exits:
- To SEARCH in the cycle after count reaches 7, or after eos=1 with count>0.
- To DONE if eos=1 and count=0.
REQ-020 SEARCH: patternData_valid=1 and patternData_length=count; bytes at or above count are driven as 0; on handshake go to WAIT.
REQ-021 WAIT: matchResult_ready=1; on handshake, capture index and length and go to EMIT.
REQ-022 Match qualification: when MIN_MATCH <= length <= count, the block emits a match token (isMatch=1, index, length) and sets rem=length.
REQ-023 Literal: otherwise the block emits a literal token (isMatch=0, literal=buf[0], length=1, index=0) and sets rem=1; length > count is therefore a literal.
REQ-024 EMIT: token_valid=1 with fields held stable until handshake, then go to RETIRE.
REQ-025 RETIRE:
- writeData_valid=1 and writeData_bits=buf[0].
- Each handshake shifts the buffer down one position, decrements count and decrements rem.
- When rem reaches 0, go to FILL.
REQ-026 Throughput: one byte per cycle in FILL and in RETIRE; there is no bypass between states.
REQ-027 Interface gating: all valid/ready outputs not named for the current state are 0, and inData_ready=0 outside FILL.
REQ-028 DONE: done=1 and all valids/readies are 0; the block stays in DONE until reset.
REQ-029 Stall: backpressure on any output holds the state and all output fields unchanged.
REQ-030 Output order: token emission strictly precedes the history write of the same bytes.

Reset
REQ-031 Asserting reset (low) asynchronously clears the FSM to FILL and clears count, rem, eos and buf to 0.
REQ-032 Reset values: all valid outputs 0, matchResult_ready 0, done 0, token fields 0; inData_ready rises to 1 combinationally from FILL.
REQ-033 Reset asserted mid-operation discards buffered bytes and any in-flight token with no further output beats.

Configuration
REQ-034 With macro LZ_LOOKAHEAD_STATS_EN defined, the block adds 16-bit outputs stat_literals and stat_matches.
REQ-035 stat_literals and stat_matches increment on each literal or match token handshake, saturate at 0xFFFF, and are cleared by reset.
REQ-036 With LZ_LOOKAHEAD_STATS_EN undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-037 Bytes 41 42 43 44 45 46 47 48 (last on 48), every result length 0 -> 8 literal tokens 41..48 in order, 8 writeData beats 41..48, done=1.
REQ-038 Bytes 00..06; first result index 0x123, length 5 -> match token (index 0x123, length 5), writeData beats 00..04, then count 2 refills to 7.
REQ-039 Result length 2 with MIN_MATCH=3 -> literal token buf[0]; result length 7 with count 3 (tail) -> literal token, not a match.
REQ-040 Single byte 0x5A with last -> pattern length 1, one literal token, one writeData beat, done; a zero-length stream (last never accepted with data) never asserts patternData_valid.
REQ-041 Hold token_ready and writeData_ready low for 10 cycles each -> outputs stable for all 10 cycles, no lost or duplicated beats; reset pulse during RETIRE -> all valids 0 immediately and inData_ready=1 after release.
REQ-042 With LZ_LOOKAHEAD_STATS_EN defined, stream producing 3 literal and 2 match tokens -> stat_literals=3, stat_matches=2.

Source files
------------

// File: rtl/lz_lookahead_buffer.sv
// lz_lookahead_buffer: 7-byte lookahead stage of an LZ77 compressor.
// Collects input bytes, asks the search stage for a match on the buffered
// lookahead, emits a literal or match token, then retires the consumed bytes
// into the search history before refilling.
// Optional feature: define LZ_LOOKAHEAD_STATS_EN to add the stat_literals /
// stat_matches token counters.
module lz_lookahead_buffer #(
    parameter int unsigned MIN_MATCH = 3,
    parameter int unsigned IDX_W     = 12
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             inData_valid,
    output logic             inData_ready,
    input  logic [7:0]       inData_bits,
    input  logic             inData_last,

    output logic             patternData_valid,
    input  logic             patternData_ready,
    output logic [55:0]      patternData_pattern,
    output logic [2:0]       patternData_length,

    input  logic             matchResult_valid,
    output logic             matchResult_ready,
    input  logic [IDX_W-1:0] matchResult_index,
    input  logic [2:0]       matchResult_length,

    output logic             writeData_valid,
    input  logic             writeData_ready,
    output logic [7:0]       writeData_bits,

    output logic             token_valid,
    input  logic             token_ready,
    output logic             token_isMatch,
    output logic [7:0]       token_literal,
    output logic [IDX_W-1:0] token_index,
    output logic [2:0]       token_length,

    output logic             done
`ifdef LZ_LOOKAHEAD_STATS_EN
    ,
    output logic [15:0]      stat_literals,
    output logic [15:0]      stat_matches
`endif
);

    typedef enum logic [2:0] {
        StFill,
        StSearch,
        StWait,
        StEmit,
        StRetire,
        StDone
    } state_e;

    state_e           r_state;
    logic [6:0][7:0]  r_buf;
    logic [2:0]       r_count;
    logic [2:0]       r_rem;
    logic             r_eos;
    logic             r_tok_is_match;
    logic [7:0]       r_tok_literal;
    logic [IDX_W-1:0] r_tok_index;
    logic [2:0]       r_tok_length;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_is_match;

    assign w_in_ready = (r_state == StFill) && (r_count != 3'd7) && !r_eos;
    assign w_in_fire  = w_in_ready && inData_valid;

    // A zero-length result never qualifies, so rem can never start at 0.
    assign w_is_match = (matchResult_length != 3'd0) &&
                        ({29'd0, matchResult_length} >= MIN_MATCH) &&
                        (matchResult_length <= r_count);

    // Control FSM, lookahead buffer and captured token fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= StFill;
            r_buf          <= '0;
            r_count        <= '0;
            r_rem          <= '0;
            r_eos          <= 1'b0;
            r_tok_is_match <= 1'b0;
            r_tok_literal  <= '0;
            r_tok_index    <= '0;
            r_tok_length   <= '0;
        end else begin
            case (r_state)
                StFill: begin
                    if (w_in_fire) begin
                        r_buf[r_count] <= inData_bits;
                        r_count        <= r_count + 3'd1;
                        if (inData_last) begin
                            r_eos <= 1'b1;
                        end
                    end
                    // Exit decisions use registered count/eos, so no byte is
                    // accepted in the cycle the state leaves FILL.
                    if ((r_count == 3'd7) || (r_eos && (r_count != 3'd0))) begin
                        r_state <= StSearch;
                    end else if (r_eos) begin
                        r_state <= StDone;
                    end
                end
                StSearch: begin
                    if (patternData_ready) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (matchResult_valid) begin
                        if (w_is_match) begin
                            r_tok_is_match <= 1'b1;
                            r_tok_literal  <= 8'h00;
                            r_tok_index    <= matchResult_index;
                            r_tok_length   <= matchResult_length;
                            r_rem          <= matchResult_length;
                        end else begin
                            r_tok_is_match <= 1'b0;
                            r_tok_literal  <= r_buf[0];
                            r_tok_index    <= '0;
                            r_tok_length   <= 3'd1;
                            r_rem          <= 3'd1;
                        end
                        r_state <= StEmit;
                    end
                end
                StEmit: begin
                    if (token_ready) begin
                        r_state <= StRetire;
                    end
                end
                StRetire: begin
                    if (writeData_ready) begin
                        r_buf   <= {8'h00, r_buf[6:1]};
                        r_count <= r_count - 3'd1;
                        r_rem   <= r_rem - 3'd1;
                        if (r_rem == 3'd1) begin
                            r_state <= StFill;
                        end
                    end
                end
                StDone: begin
                    r_state <= StDone;
                end
                default: begin
                    r_state <= StFill;
                end
            endcase
        end
    end

    // Interface decode from the registered state; unused bytes of the pattern read as 0.
    always_comb begin
        inData_ready        = w_in_ready;
        patternData_valid   = (r_state == StSearch);
        patternData_length  = r_count;
        matchResult_ready   = (r_state == StWait);
        token_valid         = (r_state == StEmit);
        writeData_valid     = (r_state == StRetire);
        writeData_bits      = r_buf[0];
        done                = (r_state == StDone);
        patternData_pattern = '0;
        for (int k = 0; k < 7; k++) begin
            if (r_count > 3'(k)) begin
                patternData_pattern[8*k +: 8] = r_buf[k];
            end
        end
    end

    assign token_isMatch = r_tok_is_match;
    assign token_literal = r_tok_literal;
    assign token_index   = r_tok_index;
    assign token_length  = r_tok_length;

`ifdef LZ_LOOKAHEAD_STATS_EN
    logic [15:0] r_stat_literals;
    logic [15:0] r_stat_matches;
    logic        w_tok_fire;

    assign w_tok_fire = (r_state == StEmit) && token_ready;

    // Saturating counts of accepted literal and match tokens.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_literals <= '0;
            r_stat_matches  <= '0;
        end else if (w_tok_fire) begin
            if (r_tok_is_match) begin
                if (r_stat_matches != 16'hFFFF) begin
                    r_stat_matches <= r_stat_matches + 16'd1;
                end
            end else begin
                if (r_stat_literals != 16'hFFFF) begin
                    r_stat_literals <= r_stat_literals + 16'd1;
                end
            end
        end
    end

    assign stat_literals = r_stat_literals;
    assign stat_matches  = r_stat_matches;
`endif

endmodule

// File: tb/tb_lz_lookahead_buffer.sv
// tb_lz_lookahead_buffer: scoreboard bench for lz_lookahead_buffer.
// Expected patterns, tokens and history writes are queued as each scenario's
// stimulus is set up and compared as the DUT presents them.
module tb_lz_lookahead_buffer;

    localparam int IDX_W = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             inData_valid = 1'b0;
    logic             inData_ready;
    logic [7:0]       inData_bits = '0;
    logic             inData_last = 1'b0;
    logic             patternData_valid;
    logic             patternData_ready = 1'b0;
    logic [55:0]      patternData_pattern;
    logic [2:0]       patternData_length;
    logic             matchResult_valid = 1'b0;
    logic             matchResult_ready;
    logic [IDX_W-1:0] matchResult_index = '0;
    logic [2:0]       matchResult_length = '0;
    logic             writeData_valid;
    logic             writeData_ready = 1'b0;
    logic [7:0]       writeData_bits;
    logic             token_valid;
    logic             token_ready = 1'b0;
    logic             token_isMatch;
    logic [7:0]       token_literal;
    logic [IDX_W-1:0] token_index;
    logic [2:0]       token_length;
    logic             done;
`ifdef LZ_LOOKAHEAD_STATS_EN
    logic [15:0]      stat_literals;
    logic [15:0]      stat_matches;
`endif

    lz_lookahead_buffer #(
        .MIN_MATCH (3),
        .IDX_W     (IDX_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .inData_valid        (inData_valid),
        .inData_ready        (inData_ready),
        .inData_bits         (inData_bits),
        .inData_last         (inData_last),
        .patternData_valid   (patternData_valid),
        .patternData_ready   (patternData_ready),
        .patternData_pattern (patternData_pattern),
        .patternData_length  (patternData_length),
        .matchResult_valid   (matchResult_valid),
        .matchResult_ready   (matchResult_ready),
        .matchResult_index   (matchResult_index),
        .matchResult_length  (matchResult_length),
        .writeData_valid     (writeData_valid),
        .writeData_ready     (writeData_ready),
        .writeData_bits      (writeData_bits),
        .token_valid         (token_valid),
        .token_ready         (token_ready),
        .token_isMatch       (token_isMatch),
        .token_literal       (token_literal),
        .token_index         (token_index),
        .token_length        (token_length),
        .done                (done)
`ifdef LZ_LOOKAHEAD_STATS_EN
        ,
        .stat_literals       (stat_literals),
        .stat_matches        (stat_matches)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             m;
        logic [7:0]       lit;
        logic [IDX_W-1:0] idx;
        logic [2:0]       len;
    } tok_t;

    typedef struct packed {
        logic [2:0]  len;
        logic [55:0] pat;
    } pat_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [2:0]       len;
    } res_t;

    logic [8:0] src_q[$];
    res_t       res_q[$];
    pat_t       pat_q[$];
    tok_t       tok_q[$];
    logic [7:0] wr_q[$];

    int n_checks    = 0;
    int n_pass      = 0;
    int tok_stall   = 0;
    int wr_stall    = 0;
    int exp_lits    = 0;
    int exp_matches = 0;
    int pat_seen    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_src(input logic [7:0] start, input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            src_q.push_back({(last_on_final && (i == n - 1)), start + 8'(i)});
        end
    endtask

    task automatic push_pat(input logic [7:0] start, input int len);
        pat_t p;
        p.len = 3'(len);
        p.pat = '0;
        for (int k = 0; k < len; k++) p.pat[8*k +: 8] = start + 8'(k);
        pat_q.push_back(p);
    endtask

    task automatic push_res(input logic [IDX_W-1:0] idx, input logic [2:0] len);
        res_t r;
        r.idx = idx;
        r.len = len;
        res_q.push_back(r);
    endtask

    task automatic push_lit(input logic [7:0] b);
        tok_t t;
        t.m = 1'b0; t.lit = b; t.idx = '0; t.len = 3'd1;
        tok_q.push_back(t);
        exp_lits++;
    endtask

    task automatic push_match(input logic [IDX_W-1:0] idx, input logic [2:0] len);
        tok_t t;
        t.m = 1'b1; t.lit = 8'h00; t.idx = idx; t.len = len;
        tok_q.push_back(t);
        exp_matches++;
    endtask

    task automatic push_wr(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) wr_q.push_back(start + 8'(i));
    endtask

    task automatic clear_all();
        src_q.delete(); res_q.delete(); pat_q.delete(); tok_q.delete(); wr_q.delete();
        tok_stall = 0; wr_stall = 0; exp_lits = 0; exp_matches = 0; pat_seen = 0;
        inData_valid = 1'b0; inData_bits = '0; inData_last = 1'b0;
        matchResult_valid = 1'b0; matchResult_index = '0; matchResult_length = '0;
        patternData_ready = 1'b0; token_ready = 1'b0; writeData_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        clear_all();
        #1;
        check_eq("rst_valids", 64'({patternData_valid, matchResult_ready, writeData_valid,
                                     token_valid, done}), 64'(0));
        check_eq("rst_token_fields", 64'({token_isMatch, token_literal, token_index,
                                           token_length}), 64'(0));
        check_eq("rst_in_ready", 64'(inData_ready), 64'(1));
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One cycle of all four agents: inputs are set and outputs sampled at the falling edge.
    task automatic step();
        pat_t p;
        res_t r;
        tok_t t;
        @(negedge clock);
        if (src_q.size() > 0) begin
            inData_valid = 1'b1;
            inData_bits  = src_q[0][7:0];
            inData_last  = src_q[0][8];
            if (inData_ready) void'(src_q.pop_front());
        end else begin
            inData_valid = 1'b0; inData_bits = '0; inData_last = 1'b0;
        end

        patternData_ready = 1'b1;
        if (patternData_valid) begin
            pat_seen++;
            if (pat_q.size() == 0) begin
                check_eq("pattern_unexpected", 64'(1), 64'(0));
            end else begin
                p = pat_q.pop_front();
                check_eq("pattern_length", 64'(patternData_length), 64'(p.len));
                check_eq("pattern_bytes", 64'(patternData_pattern), 64'(p.pat));
            end
        end

        if (matchResult_ready && (res_q.size() > 0)) begin
            r = res_q.pop_front();
            matchResult_valid = 1'b1; matchResult_index = r.idx; matchResult_length = r.len;
        end else begin
            matchResult_valid = 1'b0; matchResult_index = '0; matchResult_length = '0;
        end

        token_ready = 1'b1;
        if (token_valid) begin
            if (tok_q.size() == 0) begin
                check_eq("token_unexpected", 64'(1), 64'(0));
            end else begin
                t = tok_q[0];
                check_eq("token_isMatch", 64'(token_isMatch), 64'(t.m));
                if (!t.m) check_eq("token_literal", 64'(token_literal), 64'(t.lit));
                check_eq("token_index", 64'(token_index), 64'(t.idx));
                check_eq("token_length", 64'(token_length), 64'(t.len));
                if (tok_stall > 0) begin
                    token_ready = 1'b0;
                    tok_stall--;
                end else begin
                    void'(tok_q.pop_front());
                end
            end
        end

        writeData_ready = 1'b1;
        if (writeData_valid) begin
            if (wr_q.size() == 0) begin
                check_eq("write_unexpected", 64'(1), 64'(0));
            end else begin
                check_eq("write_bits", 64'(writeData_bits), 64'(wr_q[0]));
                if (wr_stall > 0) begin
                    writeData_ready = 1'b0;
                    wr_stall--;
                end else begin
                    void'(wr_q.pop_front());
                end
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (!(done && (tok_q.size() == 0) && (wr_q.size() == 0)) && (n < budget)) begin
            step();
            n++;
        end
        check_eq("done_reached", 64'(done), 64'(1));
        check_eq("tokens_drained", 64'(tok_q.size()), 64'(0));
        check_eq("writes_drained", 64'(wr_q.size()), 64'(0));
        check_eq("patterns_drained", 64'(pat_q.size()), 64'(0));
        check_eq("stalls_consumed", 64'(tok_stall + wr_stall), 64'(0));
    endtask

    task automatic check_stats();
`ifdef LZ_LOOKAHEAD_STATS_EN
        check_eq("stat_literals", 64'(stat_literals), 64'(exp_lits));
        check_eq("stat_matches", 64'(stat_matches), 64'(exp_matches));
`endif
    endtask

    initial begin
        int n;

        // Eight literal tokens, then the same stream with token/write backpressure.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            push_src(8'h41, 8, 1'b1);
            for (int i = 0; i < 8; i++) begin
                push_pat(8'h41 + 8'(i), ((8 - i) > 7) ? 7 : (8 - i));
                push_res('0, 3'd0);
                push_lit(8'h41 + 8'(i));
            end
            push_wr(8'h41, 8);
            if (v == 1) begin
                tok_stall = 10;
                wr_stall  = 10;
            end
            run_until_done(600);
            check_stats();
        end

        // Match of 5, refill to 7, literals for short/overlong results, final match.
        do_reset();
        push_src(8'h00, 12, 1'b1);
        push_pat(8'h00, 7); push_res(12'h123, 3'd5); push_match(12'h123, 3'd5);
        push_pat(8'h05, 7); push_res(12'h000, 3'd0); push_lit(8'h05);
        push_pat(8'h06, 6); push_res(12'h000, 3'd2); push_lit(8'h06);
        push_pat(8'h07, 5); push_res(12'h000, 3'd7); push_lit(8'h07);
        push_pat(8'h08, 4); push_res(12'h200, 3'd4); push_match(12'h200, 3'd4);
        push_wr(8'h00, 12);
        run_until_done(600);
        check_stats();

        // Length 2 below minimum, and length 7 against a 3-byte tail.
        do_reset();
        push_src(8'h10, 10, 1'b1);
        push_pat(8'h10, 7); push_res(12'h000, 3'd2); push_lit(8'h10);
        push_pat(8'h11, 7); push_res(12'h0AB, 3'd3); push_match(12'h0AB, 3'd3);
        push_pat(8'h14, 6); push_res(12'h0CD, 3'd3); push_match(12'h0CD, 3'd3);
        push_pat(8'h17, 3); push_res(12'h000, 3'd7); push_lit(8'h17);
        push_pat(8'h18, 2); push_res(12'h000, 3'd0); push_lit(8'h18);
        push_pat(8'h19, 1); push_res(12'h000, 3'd0); push_lit(8'h19);
        push_wr(8'h10, 10);
        run_until_done(600);
        check_stats();

        // Single-byte stream.
        do_reset();
        push_src(8'h5A, 1, 1'b1);
        push_pat(8'h5A, 1); push_res(12'h000, 3'd0); push_lit(8'h5A);
        push_wr(8'h5A, 1);
        run_until_done(200);
        check_stats();

        // Zero-length stream never issues a pattern request.
        do_reset();
        repeat (30) step();
        check_eq("zero_len_no_pattern", 64'(pat_seen), 64'(0));
        check_eq("zero_len_not_done", 64'(done), 64'(0));
        check_eq("zero_len_in_ready", 64'(inData_ready), 64'(1));

        // Reset pulse while retiring discards everything in flight.
        do_reset();
        push_src(8'h60, 7, 1'b0);
        push_pat(8'h60, 7); push_res(12'h000, 3'd0); push_lit(8'h60);
        push_wr(8'h60, 1);
        wr_stall = 5;
        n = 0;
        while (!writeData_valid && (n < 100)) begin
            step();
            n++;
        end
        check_eq("reached_retire", 64'(writeData_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_valids", 64'({patternData_valid, matchResult_ready, writeData_valid,
                                        token_valid, done}), 64'(0));
        clear_all();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("midrst_in_ready", 64'(inData_ready), 64'(1));
        repeat (20) step();
        check_eq("midrst_no_pattern", 64'(pat_seen), 64'(0));
        check_eq("midrst_idle_valids", 64'({writeData_valid, token_valid}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
